// File: rtl/wb_memory_banked.sv
// rtl/wb_memory_banked.sv - Wishbone classic slave bridging one 32-bit port to NUM_BANKS SRAM macros
//
// Purpose: decodes a byte address into (bank, word), drives registered active-low
// csb/web, byte wmask, address and write data to single-port SRAM macros, and
// returns registered read data with a one-cycle ack (or err for unmapped banks).
//
// Ports:
//   io_wbs_clk, io_wbs_rst          clock, synchronous active-high reset
//   io_wbs_adr/datwr/we/sel/stb/cyc Wishbone request inputs
//   io_wbs_datrd/ack/err            Wishbone response outputs (registered)
//   csb_mem, web_mem                per-bank chip select / write enable, active low
//   wmask_mem, addr_mem, din_mem    per-bank byte mask, word address, write data
//   dout_mem                        per-bank read data from the macros
module wb_memory_banked #(
    parameter int NUM_BANKS    = 2,
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 1,
    parameter int ERR_EN       = 1
) (
    input  logic                            io_wbs_clk,
    input  logic                            io_wbs_rst,
    input  logic [31:0]                     io_wbs_adr,
    input  logic [31:0]                     io_wbs_datwr,
    output logic [31:0]                     io_wbs_datrd,
    input  logic                            io_wbs_we,
    input  logic [3:0]                      io_wbs_sel,
    input  logic                            io_wbs_stb,
    input  logic                            io_wbs_cyc,
    output logic                            io_wbs_ack,
    output logic                            io_wbs_err,
    output logic [NUM_BANKS-1:0]            csb_mem,
    output logic [NUM_BANKS-1:0]            web_mem,
    output logic [4*NUM_BANKS-1:0]          wmask_mem,
    output logic [ADDR_WIDTH*NUM_BANKS-1:0] addr_mem,
    output logic [32*NUM_BANKS-1:0]         din_mem,
    input  logic [32*NUM_BANKS-1:0]         dout_mem
);

    localparam int BB       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int BANK_LSB = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [BB-1:0]          bank_q, bank_d;
    logic                   we_q, we_d;
    logic                   null_q, null_d;
    logic                   unmapped_q, unmapped_d;
    logic [2:0]             wait_cnt_q, wait_cnt_d;
    logic [NUM_BANKS-1:0]   csb_q, csb_d;
    logic                   web_q, web_d;
    logic [3:0]             wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [31:0]            din_q, din_d;
    logic [31:0]            datrd_q, datrd_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;

    logic [BB-1:0]          req_bank;
    logic [ADDR_WIDTH-1:0]  req_word;
    logic                   req_unmapped;
    logic [NUM_BANKS-1:0]   req_csb;
    logic [31:0]            dout_sel;
    logic                   unused_adr_bits;

    assign req_bank        = io_wbs_adr[BANK_LSB +: BB];
    assign req_word        = io_wbs_adr[ADDR_WIDTH+1:2];
    assign req_unmapped    = (32'(req_bank) >= NUM_BANKS);
    assign unused_adr_bits = ^{io_wbs_adr[1:0], io_wbs_adr[31:BANK_LSB+BB]};

    // One-cold select; loop compare keeps the index in range when NUM_BANKS is not a power of 2.
    always_comb begin
        req_csb = '1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (32'(req_bank) == b) begin
                req_csb[b] = 1'b0;
            end
        end
    end

    always_comb begin
        dout_sel = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (32'(bank_q) == b) begin
                dout_sel = dout_mem[32*b +: 32];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        we_d       = we_q;
        null_d     = null_q;
        unmapped_d = unmapped_q;
        wait_cnt_d = wait_cnt_q;
        csb_d      = csb_q;
        web_d      = web_q;
        wmask_d    = wmask_q;
        addr_d     = addr_q;
        din_d      = din_q;
        datrd_d    = datrd_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (io_wbs_cyc && io_wbs_stb) begin
                    bank_d     = req_bank;
                    we_d       = io_wbs_we;
                    unmapped_d = req_unmapped;
                    // Unmapped banks and empty writes still spend the ACCESS cycle
                    // (without touching a macro) so every non-read ack lands at T+2.
                    null_d     = req_unmapped || (io_wbs_we && (io_wbs_sel == 4'b0000));
                    state_d    = ACCESS;
                    if (!(req_unmapped || (io_wbs_we && (io_wbs_sel == 4'b0000)))) begin
                        csb_d   = req_csb;
                        web_d   = ~io_wbs_we;
                        wmask_d = io_wbs_we ? io_wbs_sel : 4'b0000;
                        addr_d  = req_word;
                        din_d   = io_wbs_datwr;
                    end
                end
            end
            ACCESS: begin
                // The macro samples on this edge, so csb/web go back high regardless.
                csb_d = '1;
                web_d = 1'b1;
                if (!io_wbs_cyc) begin
                    state_d = IDLE;
                end else if (null_q || we_q) begin
                    state_d = ACK;
                    if (unmapped_q) begin
                        datrd_d = '0;
                        if (ERR_EN != 0) begin
                            err_d = 1'b1;
                        end else begin
                            ack_d = 1'b1;
                        end
                    end else begin
                        ack_d = 1'b1;
                    end
                end else begin
                    state_d    = WAIT;
                    wait_cnt_d = 3'(READ_LATENCY - 1);
                end
            end
            WAIT: begin
                if (!io_wbs_cyc) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == 3'd0) begin
                    datrd_d = dout_sel;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst) begin
            state_q    <= IDLE;
            bank_q     <= '0;
            we_q       <= 1'b0;
            null_q     <= 1'b0;
            unmapped_q <= 1'b0;
            wait_cnt_q <= '0;
            csb_q      <= '1;
            web_q      <= 1'b1;
            wmask_q    <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            datrd_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            we_q       <= we_d;
            null_q     <= null_d;
            unmapped_q <= unmapped_d;
            wait_cnt_q <= wait_cnt_d;
            csb_q      <= csb_d;
            web_q      <= web_d;
            wmask_q    <= wmask_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            datrd_q    <= datrd_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign io_wbs_datrd = datrd_q;
    assign io_wbs_ack   = ack_q;
    assign io_wbs_err   = err_q;
    assign csb_mem      = csb_q;
    assign web_mem      = {NUM_BANKS{web_q}};
    assign wmask_mem    = {NUM_BANKS{wmask_q}};
    assign addr_mem     = {NUM_BANKS{addr_q}};
    assign din_mem      = {NUM_BANKS{din_q}};

endmodule

// File: tb/tb_wb_memory_banked.sv
// tb/tb_wb_memory_banked.sv - directed self-checking bench for wb_memory_banked
module tb_wb_memory_banked;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0;
    logic [31:0] datwr = '0;
    logic        we = 1'b0;
    logic [3:0]  sel = '0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Instance A: 2 banks, read latency 1, err enabled
    logic [31:0] datrd_a;
    logic        ack_a, err_a;
    logic [1:0]  csb_a, web_a;
    logic [7:0]  wmask_a;
    logic [17:0] addr_a;
    logic [63:0] din_a, dout_a;

    // Instance B: 3 banks, read latency 3, err enabled
    logic [31:0] datrd_b;
    logic        ack_b, err_b;
    logic [2:0]  csb_b, web_b;
    logic [11:0] wmask_b;
    logic [26:0] addr_b;
    logic [95:0] din_b, dout_b;

    // Instance C: 3 banks, read latency 3, unmapped answered with ack
    logic [31:0] datrd_c;
    logic        ack_c, err_c;
    logic [2:0]  csb_c, web_c;
    logic [11:0] wmask_c;
    logic [26:0] addr_c;
    logic [95:0] din_c;
    logic [95:0] dout_c = {3{32'h5A5A_0C0C}};

    wb_memory_banked #(.NUM_BANKS(2), .ADDR_WIDTH(9), .READ_LATENCY(1), .ERR_EN(1)) dut_a (
        .io_wbs_clk(clk), .io_wbs_rst(rst), .io_wbs_adr(adr), .io_wbs_datwr(datwr),
        .io_wbs_datrd(datrd_a), .io_wbs_we(we), .io_wbs_sel(sel), .io_wbs_stb(stb),
        .io_wbs_cyc(cyc), .io_wbs_ack(ack_a), .io_wbs_err(err_a), .csb_mem(csb_a),
        .web_mem(web_a), .wmask_mem(wmask_a), .addr_mem(addr_a), .din_mem(din_a),
        .dout_mem(dout_a)
    );

    wb_memory_banked #(.NUM_BANKS(3), .ADDR_WIDTH(9), .READ_LATENCY(3), .ERR_EN(1)) dut_b (
        .io_wbs_clk(clk), .io_wbs_rst(rst), .io_wbs_adr(adr), .io_wbs_datwr(datwr),
        .io_wbs_datrd(datrd_b), .io_wbs_we(we), .io_wbs_sel(sel), .io_wbs_stb(stb),
        .io_wbs_cyc(cyc), .io_wbs_ack(ack_b), .io_wbs_err(err_b), .csb_mem(csb_b),
        .web_mem(web_b), .wmask_mem(wmask_b), .addr_mem(addr_b), .din_mem(din_b),
        .dout_mem(dout_b)
    );

    wb_memory_banked #(.NUM_BANKS(3), .ADDR_WIDTH(9), .READ_LATENCY(3), .ERR_EN(0)) dut_c (
        .io_wbs_clk(clk), .io_wbs_rst(rst), .io_wbs_adr(adr), .io_wbs_datwr(datwr),
        .io_wbs_datrd(datrd_c), .io_wbs_we(we), .io_wbs_sel(sel), .io_wbs_stb(stb),
        .io_wbs_cyc(cyc), .io_wbs_ack(ack_c), .io_wbs_err(err_c), .csb_mem(csb_c),
        .web_mem(web_c), .wmask_mem(wmask_c), .addr_mem(addr_c), .din_mem(din_c),
        .dout_mem(dout_c)
    );

    // SRAM models: A returns data one edge after sampling, B three edges after.
    logic [31:0] mem_a [2][512];
    logic [31:0] mem_b [3][512];
    logic [31:0] rd_a [2];
    logic [31:0] rd_b [3];
    logic [31:0] p1_b [3];
    logic [31:0] p2_b [3];

    initial begin
        for (int b = 0; b < 2; b++) begin
            rd_a[b] = '0;
            for (int w = 0; w < 512; w++) mem_a[b][w] = '0;
        end
        for (int b = 0; b < 3; b++) begin
            rd_b[b] = '0; p1_b[b] = '0; p2_b[b] = '0;
            for (int w = 0; w < 512; w++) mem_b[b][w] = '0;
        end
    end

    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (!csb_a[b]) begin
                if (!web_a[b]) begin
                    for (int k = 0; k < 4; k++)
                        if (wmask_a[4*b+k]) mem_a[b][addr_a[9*b +: 9]][8*k +: 8] <= din_a[32*b+8*k +: 8];
                end else begin
                    rd_a[b] <= mem_a[b][addr_a[9*b +: 9]];
                end
            end
        end
    end

    always @(posedge clk) begin
        for (int b = 0; b < 3; b++) begin
            if (!csb_b[b]) begin
                if (!web_b[b]) begin
                    for (int k = 0; k < 4; k++)
                        if (wmask_b[4*b+k]) mem_b[b][addr_b[9*b +: 9]][8*k +: 8] <= din_b[32*b+8*k +: 8];
                end else begin
                    rd_b[b] <= mem_b[b][addr_b[9*b +: 9]];
                end
            end
            p1_b[b] <= rd_b[b];
            p2_b[b] <= p1_b[b];
        end
    end

    assign dout_a = {rd_a[1], rd_a[0]};
    assign dout_b = {p2_b[2], p2_b[1], p2_b[0]};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        cyc = 1'b0;
        stb = 1'b0;
        repeat (n) tick();
    endtask

    // Present a request in cycle T; returns in cycle T+1 with stb dropped and adr scrambled.
    task automatic start(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        we = w; adr = a; datwr = d; sel = s;
        cyc = 1'b1; stb = 1'b1;
        tick();
        stb = 1'b0;
        adr = 32'hFFFF_FFFF;
        datwr = 32'h0BAD_0BAD;
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_csb_a", csb_a, 2'b11);
        check("rst_web_a", web_a, 2'b11);
        check("rst_wmask_a", wmask_a, 8'h00);
        check("rst_addr_a", addr_a, 18'h0);
        check("rst_din_a", din_a, 64'h0);
        check("rst_datrd_a", datrd_a, 32'h0);
        check("rst_ack_a", ack_a, 1'b0);
        check("rst_err_a", err_a, 1'b0);
        rst = 1'b0;
        idle(2);

        // 1: write 0x804 to bank 1 word 1
        start(1'b1, 32'h0000_0804, 32'hDEAD_BEEF, 4'hF);
        check("t1_csb", csb_a, 2'b01);
        check("t1_web1", web_a[1], 1'b0);
        check("t1_addr", addr_a[17:9], 9'h001);
        check("t1_wmask", wmask_a[7:4], 4'hF);
        check("t1_din", din_a[63:32], 32'hDEAD_BEEF);
        check("t1_ack_t1", ack_a, 1'b0);
        tick();
        check("t1_ack_t2", ack_a, 1'b1);
        check("t1_csb_t2", csb_a, 2'b11);
        check("t1_err_t2", err_a, 1'b0);
        tick();
        check("t1_ack_t3", ack_a, 1'b0);
        idle(6);

        // 2: read back, RL=1 ack at T+3, RL=3 ack at T+5
        start(1'b0, 32'h0000_0804, 32'h0, 4'hF);
        check("t2_csb_b", csb_b, 3'b101);
        check("t2_web_b", web_b, 3'b111);
        tick();
        check("t2_ack_a_t2", ack_a, 1'b0);
        tick();
        check("t2_ack_a_t3", ack_a, 1'b1);
        check("t2_datrd_a", datrd_a, 32'hDEAD_BEEF);
        check("t2_ack_b_t3", ack_b, 1'b0);
        tick();
        check("t2_ack_b_t4", ack_b, 1'b0);
        tick();
        check("t2_ack_b_t5", ack_b, 1'b1);
        check("t2_datrd_b", datrd_b, 32'hDEAD_BEEF);
        check("t2_datrd_c", datrd_c, 32'h5A5A_0C0C);
        tick();
        check("t2_ack_b_t6", ack_b, 1'b0);
        idle(4);

        // 3: partial byte write and read back, then empty-mask write
        start(1'b1, 32'h0000_0808, 32'h1122_3344, 4'b0100);
        check("t3_wmask", wmask_a[7:4], 4'b0100);
        check("t3_addr", addr_a[17:9], 9'h002);
        idle(6);
        start(1'b0, 32'h0000_0808, 32'h0, 4'hF);
        tick();
        tick();
        check("t3_rd_ack", ack_a, 1'b1);
        check("t3_rd_data", datrd_a, 32'h0022_0000);
        idle(6);
        start(1'b1, 32'h0000_080C, 32'h5555_5555, 4'b0000);
        check("t3_sel0_csb", csb_a, 2'b11);
        check("t3_sel0_ack_t1", ack_a, 1'b0);
        tick();
        check("t3_sel0_ack_t2", ack_a, 1'b1);
        idle(6);

        // 4: unmapped bank 3 on the 3-bank instances
        start(1'b0, 32'h0000_1800, 32'h0, 4'hF);
        check("t4_csb_b", csb_b, 3'b111);
        check("t4_csb_c", csb_c, 3'b111);
        tick();
        check("t4_err_b", err_b, 1'b1);
        check("t4_ack_b", ack_b, 1'b0);
        check("t4_datrd_b", datrd_b, 32'h0);
        check("t4_ack_c", ack_c, 1'b1);
        check("t4_err_c", err_c, 1'b0);
        check("t4_datrd_c", datrd_c, 32'h0);
        tick();
        check("t4_err_b_t3", err_b, 1'b0);
        idle(6);

        // 5: RL=3 read aborted in T+2, then a write acked in T+2
        start(1'b0, 32'h0000_0804, 32'h0, 4'hF);
        tick();
        cyc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_abort_ack_b", ack_b, 1'b0);
            check("t5_abort_err_b", err_b, 1'b0);
            check("t5_abort_ack_a", ack_a, 1'b0);
        end
        check("t5_datrd_b_kept", datrd_b, 32'h0);
        start(1'b1, 32'h0000_0810, 32'hCAFE_F00D, 4'hF);
        check("t5_wr_csb_b", csb_b, 3'b101);
        tick();
        check("t5_wr_ack_b", ack_b, 1'b1);
        idle(6);
        start(1'b0, 32'h0000_0810, 32'h0, 4'hF);
        repeat (4) tick();
        check("t5_rd_ack_b", ack_b, 1'b1);
        check("t5_rd_data_b", datrd_b, 32'hCAFE_F00D);
        idle(6);

        // 6: reset asserted while B waits on its read
        start(1'b0, 32'h0000_0810, 32'h0, 4'hF);
        tick();
        rst = 1'b1;
        tick();
        check("t6_csb_b", csb_b, 3'b111);
        check("t6_web_b", web_b, 3'b111);
        check("t6_wmask_b", wmask_b, 12'h0);
        check("t6_addr_b", addr_b, 27'h0);
        check("t6_din_b", din_b, 96'h0);
        check("t6_datrd_b", datrd_b, 32'h0);
        check("t6_ack_b", ack_b, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_post_ack_b", ack_b, 1'b0);
            check("t6_post_err_b", err_b, 1'b0);
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
